// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of pending {addr, data} stores drained into the memory write port when no load uses it.
// Optional STORE_COALESCE_EN: a store hitting the youngest entry overwrites its data in place.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     St_valid,
  input  logic [AW-1:0]            St_addr,
  input  logic [DW-1:0]            St_data,
  output logic                     St_ready,
  input  logic                     Ld_valid,
  input  logic [AW-1:0]            Ld_addr,
  output logic                     Ld_hit,
  output logic [DW-1:0]            Ld_data,
  output logic                     Memwrite,
  output logic [AW-1:0]            Mem_addr,
  output logic [DW-1:0]            Datawrite,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic coal;

  // Handshake: a store transfers on the rising edge where St_valid && St_ready;
  // St_ready is a function of current state only, never of the same-cycle pop.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    Memwrite = !empty && !Ld_valid;
    pop      = Memwrite;
  end

`ifdef STORE_COALESCE_EN
  logic [PW-1:0] tail_m1;
  logic          coal_match;

  // The youngest entry is also the head when only one is buffered; if it drains now it cannot be merged.
  always_comb begin
    tail_m1    = tail_q - PW'(1);
    coal_match = !empty && (addr_q[tail_m1] == St_addr) &&
                 !((count_q == CW'(1)) && Memwrite);
    coal       = St_valid && coal_match;
    St_ready   = !full || coal_match;
  end
`else
  always_comb begin
    coal     = 1'b0;
    St_ready = !full;
  end
`endif

  assign push = St_valid && St_ready && !coal;

  // Walk oldest to youngest so the last match wins, giving the youngest store's data.
  always_comb begin
    Ld_hit  = 1'b0;
    Ld_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx = head_q + PW'(i);
      if (Ld_valid && valid_q[idx] && (addr_q[idx] == Ld_addr)) begin
        Ld_hit  = 1'b1;
        Ld_data = data_q[idx];
      end
    end
  end

  always_comb begin
    Mem_addr  = empty ? '0 : addr_q[head_q];
    Datawrite = empty ? '0 : data_q[head_q];
    Count     = count_q;
    Empty     = empty;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        addr_q[tail_q]  <= St_addr;
        data_q[tail_q]  <= St_data;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
`ifdef STORE_COALESCE_EN
      if (coal) begin
        data_q[tail_m1] <= St_data;
      end
`endif
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: hand-computed vectors plus an expected-write queue checked at every memory write.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clk;
  logic          Rst;
  logic          St_valid;
  logic [AW-1:0] St_addr;
  logic [DW-1:0] St_data;
  logic          St_ready;
  logic          Ld_valid;
  logic [AW-1:0] Ld_addr;
  logic          Ld_hit;
  logic [DW-1:0] Ld_data;
  logic          Memwrite;
  logic [AW-1:0] Mem_addr;
  logic [DW-1:0] Datawrite;
  logic [CW-1:0] Count;
  logic          Empty;

  int total = 0;
  int bad   = 0;
  logic [AW+DW-1:0] exp_q[$];

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Rst(Rst),
    .St_valid(St_valid), .St_addr(St_addr), .St_data(St_data), .St_ready(St_ready),
    .Ld_valid(Ld_valid), .Ld_addr(Ld_addr), .Ld_hit(Ld_hit), .Ld_data(Ld_data),
    .Memwrite(Memwrite), .Mem_addr(Mem_addr), .Datawrite(Datawrite),
    .Count(Count), .Empty(Empty)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    St_valid = 1'b1;
    St_addr  = a;
    St_data  = d;
    tick();
    St_valid = 1'b0;
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // scoreboard: every write the DUT commits on the next rising edge is matched here
  always @(negedge Clk) begin
    if (!Rst && Memwrite) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {Mem_addr, Datawrite}, 32'hDEAD_BEEF);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(Mem_addr), 32'(e[AW+DW-1:DW]));
        check("wr_data", 32'(Datawrite), 32'(e[DW-1:0]));
      end
    end
  end

  initial begin
    Rst = 1'b1; St_valid = 1'b0; St_addr = '0; St_data = '0;
    Ld_valid = 1'b0; Ld_addr = '0;
    tick(); tick();
    check("rst_st_ready", 32'(St_ready), 32'd1);
    check("rst_empty",    32'(Empty), 32'd1);
    check("rst_count",    32'(Count), 32'd0);
    check("rst_memwrite", 32'(Memwrite), 32'd0);
    check("rst_ld_hit",   32'(Ld_hit), 32'd0);
    check("rst_ld_data",  32'(Ld_data), 32'd0);
    check("rst_mem_addr", 32'(Mem_addr), 32'd0);
    check("rst_datawrite", 32'(Datawrite), 32'd0);
    Rst = 1'b0;
    tick();

    // single store drains the following cycle
    expect_write(16'h0003, 16'h0007);
    store(16'h0003, 16'h0007);
    check("t1_count",     32'(Count), 32'd1);
    check("t1_memwrite",  32'(Memwrite), 32'd1);
    check("t1_mem_addr",  32'(Mem_addr), 32'h3);
    check("t1_datawrite", 32'(Datawrite), 32'h7);
    tick();
    check("t1_empty", 32'(Empty), 32'd1);

    // load held high: fill, reject fifth, then drain in order
    Ld_valid = 1'b1; Ld_addr = 16'h0002;
    store(16'h0000, 16'd20);
    store(16'h0001, 16'd5);
    store(16'h0002, 16'd15);
    store(16'h0003, 16'd7);
    check("t2_count_full", 32'(Count), 32'd4);
    check("t2_st_ready",   32'(St_ready), 32'd0);
    check("t2_memwrite",   32'(Memwrite), 32'd0);
    check("t2_fwd_hit",    32'(Ld_hit), 32'd1);
    check("t2_fwd_data",   32'(Ld_data), 32'd15);
    store(16'h0009, 16'd99);
    check("t2_fifth_rejected", 32'(Count), 32'd4);
    expect_write(16'h0000, 16'd20);
    expect_write(16'h0001, 16'd5);
    expect_write(16'h0002, 16'd15);
    expect_write(16'h0003, 16'd7);
    Ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_addr", 32'(Mem_addr), 32'(i));
      check("t2_drain_count", 32'(Count), 32'(4 - i));
      tick();
    end
    check("t2_empty", 32'(Empty), 32'd1);

    // forwarding picks the youngest match; same-cycle store is invisible
    Ld_valid = 1'b1; Ld_addr = 16'h0005;
    store(16'h0005, 16'd3);
    St_valid = 1'b1; St_addr = 16'h0005; St_data = 16'd19;
    #1;
    check("t3_same_cycle_data", 32'(Ld_data), 32'd3);
    tick();
    St_valid = 1'b0;
    check("t3_hit",  32'(Ld_hit), 32'd1);
    check("t3_data", 32'(Ld_data), 32'd19);
    Ld_addr = 16'h0006;
    #1;
    check("t3_miss_hit",  32'(Ld_hit), 32'd0);
    check("t3_miss_data", 32'(Ld_data), 32'd0);
    expect_write(16'h0005, 16'd3);
    expect_write(16'h0005, 16'd19);
    Ld_valid = 1'b0;
    tick(); tick();
    check("t3_empty", 32'(Empty), 32'd1);

    // full buffer with a pending store: pop only, then accept; push+pop holds Count
    Ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) store(16'(16'h0010 + i), 16'(16'h0100 + i));
    for (int i = 0; i < 6; i++) expect_write(16'(16'h0010 + i), 16'(16'h0100 + i));
    Ld_valid = 1'b0;
    St_valid = 1'b1; St_addr = 16'h0014; St_data = 16'h0104;
    #1;
    check("t4_full_ready", 32'(St_ready), 32'd0);
    tick();
    check("t4_pop_only", 32'(Count), 32'd3);
    check("t4_ready_after_pop", 32'(St_ready), 32'd1);
    tick();
    St_valid = 1'b0;
    check("t4_push_pop_3", 32'(Count), 32'd3);
    tick();
    check("t4_count_2", 32'(Count), 32'd2);
    store(16'h0015, 16'h0105);
    check("t4_push_pop_2", 32'(Count), 32'd2);
    tick(); tick();
    check("t4_empty", 32'(Empty), 32'd1);

    // async reset mid-clock discards pending stores
    Ld_valid = 1'b1;
    store(16'h0020, 16'h0AAA);
    store(16'h0021, 16'h0BBB);
    store(16'h0022, 16'h0CCC);
    check("t5_count_3", 32'(Count), 32'd3);
    #3;
    Ld_valid = 1'b0;
    Rst = 1'b1;
    #1;
    check("t5_rst_count",    32'(Count), 32'd0);
    check("t5_rst_memwrite", 32'(Memwrite), 32'd0);
    check("t5_rst_empty",    32'(Empty), 32'd1);
    tick(); tick();
    Rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t5_post_empty", 32'(Empty), 32'd1);

`ifdef STORE_COALESCE_EN
    // coalescing into the youngest entry
    Ld_valid = 1'b1;
    store(16'h0004, 16'd18);
    store(16'h0004, 16'd8);
    check("t6_coal_count", 32'(Count), 32'd1);
    expect_write(16'h0004, 16'd8);
    Ld_valid = 1'b0;
    tick();
    check("t6_empty", 32'(Empty), 32'd1);
`endif

    tick();
    check("exp_q_left", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer directly upstream of the data memory, between the execute stage and the memory port.
- Accepts store requests from the CPU, holds up to DEPTH pending stores in FIFO order, and drains them one per cycle into the memory's write port whenever the CPU is not using that port for a load.
- Provides store-to-load forwarding, so a load to an address with a pending store returns the buffered data in the same cycle.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- AW, 16, address width.
- DW, 16, data width.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- St_valid  input  1  store request this cycle.
- St_addr  input  AW  store address.
- St_data  input  DW  store data.
- St_ready  output  1  store is accepted when St_valid && St_ready.
- Ld_valid  input  1  CPU load is using the memory port this cycle.
- Ld_addr  input  AW  load address.
- Ld_hit  output  1  a buffered entry matches Ld_addr.
- Ld_data  output  DW  data of the youngest matching entry; 0 when no hit.
- Memwrite  output  1  write strobe to the data memory.
- Mem_addr  output  AW  write address to the data memory (head entry).
- Datawrite  output  DW  write data to the data memory (head entry).
- Count  output  log2(DEPTH)+1  number of valid entries.
- Empty  output  1  Count==0; CPU uses it as a fence.

Behaviour:
- Storage and pointers:
  - Circular array of DEPTH {addr, data} entries.
  - Head and tail pointers of log2(DEPTH) bits each; they wrap from DEPTH-1 to 0.
  - Count is a separate register.
- Reset (async, Rst=1):
  - head, tail and Count go to 0 and all entries are invalidated.
  - Outputs during and after reset: St_ready=1, Empty=1, Memwrite=0, Ld_hit=0, Ld_data=0.
  - Mem_addr and Datawrite are 0 while the buffer is empty.
  - Assertion mid-operation discards pending stores without writing them to memory.
- Push:
  - St_ready = (Count != DEPTH). This is combinational and does not depend on a same-cycle pop, so a full buffer never accepts a store.
  - On the rising edge with St_valid && St_ready, write the entry at tail and increment tail.
- Drain:
  - Memwrite = !Empty && !Ld_valid. It is combinational; memory writes on the same edge.
  - Mem_addr and Datawrite present the head entry at all times, or 0 when empty.
  - On the rising edge with Memwrite=1, increment head. Each entry is written exactly once.
- Count next value = Count + push - pop. A simultaneous push and pop leaves Count unchanged.
- Forwarding (combinational):
  - Ld_hit=1 when Ld_valid and any valid entry address equals Ld_addr.
  - Ld_data comes from the youngest matching entry, i.e. nearest to tail.
  - A store accepted in the same cycle is not visible; it is visible from the next cycle.
  - The head entry remains visible during the cycle it drains.
- Latency:
  - A store is visible to loads one cycle after acceptance.
  - It reaches memory no earlier than one cycle after acceptance.
- Ordering: memory writes occur in acceptance order; same-address stores are never reordered.
- Ld_valid held high indefinitely stalls draining. The buffer fills, then St_ready=0. There is no deadlock because the CPU must drop Ld_valid.

Optional Feature:
- Macro: STORE_COALESCE_EN.
- Defined:
  - A store whose St_addr matches the youngest valid entry (tail-1) overwrites that entry's data in place. Count and tail are unchanged.
  - Such a store is accepted even when full, so St_ready=1 for a matching address.
  - Exception: if that entry is also the head and Memwrite=1 this cycle, the store allocates normally and is subject to full.
- Undefined: every accepted store allocates a new entry, and St_ready depends only on Count.

Test Plan:
- Reset, then store (0x0003, 0x0007) with Ld_valid=0:
  - Next cycle: Count=1, Memwrite=1, Mem_addr=0x0003, Datawrite=0x0007.
  - Following cycle: Empty=1.
- Ld_valid=1 held, four stores to 0x0000..0x0003 with data 20, 5, 15, 7:
  - Count=4, St_ready=0, and a fifth store is not accepted.
  - Drop Ld_valid: four Memwrite cycles in order with addresses 0..3.
- Ld_valid=1, stores (0x0005, 3) then (0x0005, 19), then load 0x0005:
  - Ld_hit=1 and Ld_data=19.
  - Load 0x0006 gives Ld_hit=0 and Ld_data=0.
- Full buffer with Ld_valid=0, St_valid=1:
  - Pop occurs but the push is rejected; Count goes 4 to 3.
  - Next cycle the push is accepted.
  - A simultaneous push and pop at Count=2 keeps Count=2.
- Assert Rst asynchronously with Count=3, mid-clock:
  - Count=0, Memwrite=0, Empty=1 immediately.
  - No further memory writes after release.
- With STORE_COALESCE_EN and Ld_valid=1:
  - Stores (0x0004, 18) then (0x0004, 8) give Count=1.
  - After Ld_valid drops, one write of 8 to 0x0004.
